// File: rtl/present_pkg.sv
// Shared widths, FSM encoding and key-schedule / bit-permutation helpers for the PRESENT-80 cores.
package present_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 80;
    localparam int unsigned RC_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_ROUND,
        ST_FINAL
    } state_t;

    function automatic logic [5:0] perm_idx(input logic [5:0] i);
        int unsigned v;
        v = (32'(i) * 32'd16) % 32'd63;
        return (i == 6'd63) ? 6'd63 : 6'(v);
    endfunction

    // out[i] = in[P(i)]: undoes the encryption bit permutation
    function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        for (int i = 0; i < 64; i++) begin
            o[i] = s[perm_idx(6'(i))];
        end
        return o;
    endfunction

    function automatic logic [KEY_W-1:0] key_rotl61(input logic [KEY_W-1:0] k);
        return {k[18:0], k[79:19]};
    endfunction

    // Forward step; the S-box nibble comes from the external present_sbox on krot[79:76]
    function automatic logic [KEY_W-1:0] fwd_update(input logic [KEY_W-1:0] krot,
                                                    input logic [3:0]       snib,
                                                    input logic [RC_W-1:0]  rc);
        return {snib, krot[75:20], krot[19:15] ^ rc, krot[14:0]};
    endfunction

    function automatic logic [KEY_W-1:0] inv_mix(input logic [KEY_W-1:0] k,
                                                 input logic [RC_W-1:0]  rc);
        return {k[79:20], k[19:15] ^ rc, k[14:0]};
    endfunction

    // Backward step; the nibble is Sinv(kmix[79:76]) from present_inv_sbox, then rotate right 61
    function automatic logic [KEY_W-1:0] inv_update(input logic [KEY_W-1:0] kmix,
                                                    input logic [3:0]       snib);
        logic [KEY_W-1:0] t;
        t = {snib, kmix[75:0]};
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// PRESENT inverse 4-bit S-box for the decryption data path and backward key schedule.
module present_inv_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'h5;  4'h1: dout = 4'hE;  4'h2: dout = 4'hF;  4'h3: dout = 4'h8;
            4'h4: dout = 4'hC;  4'h5: dout = 4'h1;  4'h6: dout = 4'h2;  4'h7: dout = 4'hD;
            4'h8: dout = 4'hB;  4'h9: dout = 4'h4;  4'hA: dout = 4'h6;  4'hB: dout = 4'h3;
            4'hC: dout = 4'h0;  4'hD: dout = 4'h7;  4'hE: dout = 4'h9;  4'hF: dout = 4'hA;
            default: dout = 4'h0;
        endcase
    end
endmodule

// File: rtl/present_sbox.sv
// PRESENT forward 4-bit S-box, used by the key expansion.
module present_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'hC;  4'h1: dout = 4'h5;  4'h2: dout = 4'h6;  4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;  4'h5: dout = 4'h0;  4'h6: dout = 4'hA;  4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;  4'h9: dout = 4'hE;  4'hA: dout = 4'hF;  4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;  4'hD: dout = 4'h7;  4'hE: dout = 4'h1;  4'hF: dout = 4'h2;
            default: dout = 4'h0;
        endcase
    end
endmodule

// File: rtl/present_dec_core.sv
// Round-based PRESENT-80 decryption core, one round per clock, start/busy/done handshake.
// Optional PRESENT_DEC_KEY_CACHE_EN caches the last expanded K(NR+1) to skip key expansion.
module present_dec_core
    import present_pkg::*;
#(
    parameter int unsigned NR = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] ct_in,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] pt_out
);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(NR);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

    state_t             fsm;
    logic [BLOCK_W-1:0] st;
    logic [KEY_W-1:0]   key;
    logic [RC_W-1:0]    rc;

`ifdef PRESENT_DEC_KEY_CACHE_EN
    logic [KEY_W-1:0]   cache_key;
    logic [KEY_W-1:0]   cache_k32;
    logic               cache_vld;
`endif

    logic [KEY_W-1:0]   key_rot, key_fwd, key_mix, key_inv;
    logic [3:0]         fwd_nib, inv_nib;
    logic [BLOCK_W-1:0] rk_xor, perm_out, sub_out;

    assign key_rot = key_rotl61(key);
    present_sbox u_key_sbox (.din(key_rot[79:76]), .dout(fwd_nib));
    assign key_fwd = fwd_update(key_rot, fwd_nib, rc);

    assign key_mix = inv_mix(key, rc);
    present_inv_sbox u_key_isbox (.din(key_mix[79:76]), .dout(inv_nib));
    assign key_inv = inv_update(key_mix, inv_nib);

    assign rk_xor   = st ^ key[79:16];
    assign perm_out = inv_perm(rk_xor);

    for (genvar g = 0; g < 16; g++) begin : g_isbox
        present_inv_sbox u_isbox (.din(perm_out[4*g +: 4]), .dout(sub_out[4*g +: 4]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm    <= ST_IDLE;
            st     <= '0;
            key    <= '0;
            rc     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pt_out <= '0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            cache_key <= '0;
            cache_k32 <= '0;
            cache_vld <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        st   <= ct_in;
                        busy <= 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        if (cache_vld && (key_in == cache_key)) begin
                            key <= cache_k32;
                            rc  <= RC_LAST;
                            fsm <= ST_ROUND;
                        end else begin
                            key       <= key_in;
                            rc        <= RC_ONE;
                            fsm       <= ST_KEYEXP;
                            cache_key <= key_in;
                            cache_vld <= 1'b0;
                        end
`else
                        key <= key_in;
                        rc  <= RC_ONE;
                        fsm <= ST_KEYEXP;
`endif
                    end
                end
                ST_KEYEXP: begin
                    key <= key_fwd;
                    if (rc == RC_LAST) begin
                        fsm <= ST_ROUND;
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        cache_k32 <= key_fwd;
                        cache_vld <= 1'b1;
`endif
                    end else begin
                        rc <= rc + RC_ONE;
                    end
                end
                ST_ROUND: begin
                    st  <= sub_out;
                    key <= key_inv;
                    rc  <= rc - RC_ONE;
                    if (rc == RC_ONE) begin
                        fsm <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    pt_out <= rk_xor;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    fsm    <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_dec_core.sv
// Directed and round-trip bench for present_dec_core (honours PRESENT_DEC_KEY_CACHE_EN).
module tb_present_dec_core;
    localparam int NR        = 31;
    localparam int LAT_FULL  = 2 * NR + 1;
    localparam int LAT_CACHE = NR + 1;
    localparam int N_RAND    = 150;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = {80{1'b1}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] ct_in = '0;
    logic [79:0] key_in = '0;
    logic        busy, done;
    logic [63:0] pt_out;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_vld = 1'b0;
    logic [79:0] m_key = '0;

    present_dec_core #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .ct_in(ct_in), .key_in(key_in),
        .busy(busy), .done(done), .pt_out(pt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] k_in);
        logic [63:0] s, t;
        logic [79:0] k;
        s = p;
        k = k_in;
        for (int r = 1; r <= NR; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            for (int i = 0; i < 63; i++) s[(i * 16) % 63] = t[i];
            s[63] = t[63];
            k = {k[18:0], k[79:19]};
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    function automatic int exp_lat(input logic [79:0] k);
`ifdef PRESENT_DEC_KEY_CACHE_EN
        return (m_vld && k == m_key) ? LAT_CACHE : LAT_FULL;
`else
        return LAT_FULL;
`endif
    endfunction

    task automatic model_done(input logic [79:0] k, input int lat);
        if (lat == LAT_FULL) begin
            m_vld = 1'b1;
            m_key = k;
        end
    endtask

    // Accepts on the next edge; returns #1 after the done edge (or after timeout)
    task automatic do_op(input string tag, input bit aligned, input logic [63:0] ct,
                         input logic [79:0] k, input logic [63:0] exp_pt);
        int lat, el;
        el = exp_lat(k);
        if (!aligned) @(negedge clk);
        start = 1'b1; ct_in = ct; key_in = k;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_pt"}, pt_out, exp_pt);
        model_done(k, el);
    endtask

    initial begin
        int dones, el, cyc;
        logic [63:0] got, p, c;
        logic [79:0] k;

        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pt", pt_out, 64'd0);
        @(negedge clk); rst = 1'b0;

        do_op("v1", 1'b0, 64'h5579C1387B228445, K0, 64'h0000000000000000);
        do_op("v2", 1'b0, 64'hE72C46C0F5945049, K1, 64'h0000000000000000);
        do_op("v3", 1'b0, 64'hA112FFC72F68417B, K0, 64'hFFFFFFFFFFFFFFFF);
        do_op("v4", 1'b0, 64'h3333DCD3213210D2, K1, 64'hFFFFFFFFFFFFFFFF);
        do_op("cache_same", 1'b0, 64'hE72C46C0F5945049, K1, 64'h0000000000000000);
        do_op("cache_diff", 1'b0, 64'h5579C1387B228445, K0, 64'h0000000000000000);

        // Start and key wiggled while busy: single done, correct result
        el = exp_lat(K0);
        @(negedge clk);
        start = 1'b1; ct_in = 64'hA112FFC72F68417B; key_in = K0;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; got = '0; cyc = 0;
        for (int i = 1; i <= 90; i++) begin
            start  = (i < el - 2) && (i % 4 == 0);
            ct_in  = {$urandom, $urandom};
            key_in = {16'($urandom), $urandom, $urandom};
            @(posedge clk); #1;
            if (done) begin
                dones++;
                got = pt_out;
                cyc = i;
            end
        end
        start = 1'b0;
        check("busy_dones", 64'(dones), 64'd1);
        check("busy_pt", got, 64'hFFFFFFFFFFFFFFFF);
        check("busy_lat", 64'(cyc), 64'(el));
        model_done(K0, el);

        // Abort with rst at cycle 40
        @(negedge clk);
        start = 1'b1; ct_in = 64'h3333DCD3213210D2; key_in = K1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_pt", pt_out, 64'd0);
        m_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_nodone", 64'(dones), 64'd0);
        do_op("after_abort", 1'b0, 64'hE72C46C0F5945049, K1, 64'h0000000000000000);

        // Back-to-back: second start issued in the done cycle
        do_op("b2b_a", 1'b0, 64'hA112FFC72F68417B, K0, 64'hFFFFFFFFFFFFFFFF);
        do_op("b2b_b", 1'b1, 64'h3333DCD3213210D2, K1, 64'hFFFFFFFFFFFFFFFF);

        // Round trip through a reference encryption model
        k = '0;
        for (int i = 0; i < N_RAND; i++) begin
            p = {$urandom, $urandom};
            if (i % 5 != 1) k = {16'($urandom), $urandom, $urandom};
            c = enc(p, k);
            do_op($sformatf("rt%0d", i), 1'b0, c, k, p);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
